// File: rtl/uart_rx_if.sv
// Receive-side signal bundle for uart_rx: control inputs, serial line and the
// delivered byte with its strobe and error flags.
interface uart_rx_if;
  logic       ena;
  logic [2:0] baud_set;
  logic       rx;
  logic [7:0] data;
  logic       rx_done;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  modport master (
    output ena, baud_set, rx,
    input  data, rx_done, frame_err, parity_err, busy
  );

  modport slave (
    input  ena, baud_set, rx,
    output data, rx_done, frame_err, parity_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver, 8N1 LSB first; define UART_RX_PARITY_EN to
// expect an even-parity bit between bit 7 and the stop bit.
module uart_rx #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic      clk,
  input  logic      reset,
  uart_rx_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state, state_nxt;
  logic        rx_p0, rx_p1, rx_p2;
  logic        fall;
  logic [15:0] div_q, div_cnt;
  logic        tick, mid, last;
  logic [3:0]  tick_idx;
  logic [2:0]  bit_idx;
  logic        samp7, samp8, bit_val;
  logic [7:0]  shift_q;
  logic        load;

  function automatic logic [15:0] div_round(input int baud);
    return 16'((CLK_HZ + 8 * baud) / (16 * baud));
  endfunction

  function automatic logic [15:0] div_for(input logic [2:0] code);
    case (code)
      3'd1:    return div_round(19200);
      3'd2:    return div_round(38400);
      3'd3:    return div_round(57600);
      3'd4:    return div_round(115200);
      default: return div_round(9600);
    endcase
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Stage p0/p1 synchronise the line, p2 is the edge-detect history.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= bus.rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  assign fall    = rx_p2 & ~rx_p1;
  assign tick    = (state != IDLE) && (div_cnt == div_q - 16'd1);
  assign mid     = tick && (tick_idx == 4'd9);
  assign last    = tick && (tick_idx == 4'd15);
  assign bit_val = maj3(samp7, samp8, rx_p1);
  assign bus.busy = (state != IDLE);

  // The rate is frozen at frame start so baud_set may change mid-frame.
  always_ff @(posedge clk) begin
    if (reset)
      div_q <= div_for(3'd0);
    else if (state == IDLE && fall && bus.ena)
      div_q <= div_for(bus.baud_set);
  end

  always_ff @(posedge clk) begin
    if (reset || !bus.ena || state == IDLE) begin
      div_cnt  <= '0;
      tick_idx <= '0;
      bit_idx  <= '0;
    end else if (tick) begin
      div_cnt  <= '0;
      tick_idx <= tick_idx + 4'd1;
      if (state == DATA && tick_idx == 4'd15)
        bit_idx <= bit_idx + 3'd1;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (tick && tick_idx == 4'd7) samp7 <= rx_p1;
    if (tick && tick_idx == 4'd8) samp8 <= rx_p1;
    if (state == DATA && mid) shift_q <= {bit_val, shift_q[7:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    if (!bus.ena) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:   if (fall) state_nxt = START;
        START: begin
          if (mid && bit_val) state_nxt = IDLE;
          else if (last)      state_nxt = DATA;
        end
        DATA: begin
          if (last && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
        PARITY: if (last) state_nxt = STOP;
        STOP: begin
          if (mid) begin
            load      = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Leaving on the stop bit's centre sample lets back-to-back frames through.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.data      <= 8'h00;
      bus.rx_done   <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      bus.rx_done <= load;
      if (load) begin
        bus.data      <= shift_q;
        bus.frame_err <= ~bit_val;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      par_err_q      <= 1'b0;
      bus.parity_err <= 1'b0;
    end else begin
      if (state == PARITY && mid) par_err_q <= (^shift_q) ^ bit_val;
      if (load) bus.parity_err <= par_err_q;
    end
  end
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule
